tpu_acc_requantizer: RTL and testbench
======================================

Name: tpu_acc_requantizer

Overview:
- Downstream stage of the TPU MAC/accumulator.
- Reads the 34-bit two's-complement accumulator through its 17-bit half-select port (out_HL / out), in two beats.
- Applies a programmable right-shift scale and re-encodes the value into the 8-bit TPU minifloat: sign[7], exp[6:3], man[2:0].
  - A value v is encoded as {norm,man} << (exp-norm), where norm = (exp != 0).
- The 8-bit result feeds the next layer's operand inputs.
- Optionally pulses the MAC's synchronous reset after each readout so the next dot product starts from zero.

Parameters:
- CLEAR_AFTER_READ, 1, when 1 acc_clear pulses with valid; when 0 acc_clear is held 0.
- SHAMT_W, 5, width of the shift-amount input (shift range 0..31).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  request one readout/convert; sampled only in IDLE
- shamt  input  SHAMT_W  right-shift scale; captured when start is accepted
- acc_half  input  17  MAC out bus; low half when out_HL=0, high half when out_HL=1
- out_HL  output  1  half select driven to the MAC
- acc_clear  output  1  one-cycle pulse, wired to the MAC reset
- busy  output  1  conversion in progress
- valid  output  1  one-cycle pulse; result and sat are valid
- result  output  8  minifloat result, held until the next valid
- sat  output  1  result saturated; held with result

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; there are no async paths.
- Reset values: out_HL=0, acc_clear=0, busy=0, valid=0, result=8'h00, sat=0. FSM goes to IDLE.
- Reset asserted mid-operation aborts the conversion with no valid and no acc_clear.
- FSM states: IDLE -> RD_LO -> RD_HI -> MAG -> ENC -> IDLE.
- IDLE:
  - On start=1: latch shamt, set busy=1, go to RD_LO. out_HL stays 0.
  - start in any other state is ignored; no queuing.
- RD_LO: capture acc_half into lo[16:0]. out_HL <= 1. Go to RD_HI.
- RD_HI:
  - out_HL is 1 for exactly this cycle. Capture acc_half into hi[16:0]. out_HL <= 0. Go to MAG.
- MAG:
  - acc = {hi,lo} (34-bit signed).
  - Register sign = acc[33] and mag = |acc| as 34-bit unsigned; -2^33 gives mag = 2^33, with no overflow.
  - Register scaled = mag >> shamt (truncating).
- ENC, result computed from scaled:
  - scaled == 0: result = 8'h00. The sign is forced to 0; no negative zero.
  - scaled < 8: exp=0, man=scaled[2:0].
  - Otherwise, with p = index of the leading one (p >= 3):
    - exp = p-2, man = scaled[p-1:p-3].
    - Round to nearest, ties away from zero, using round bit scaled[p-4] when p >= 4. Sticky bits are ignored, so a set round bit alone rounds up.
    - Round carry: man=7 plus 1 gives man=0, exp+1.
  - Saturation: if p > 17, or the rounded exp reaches 16, then exp=15, man=7 (magnitude 245760) and sat=1.
  - result = {sign, exp[3:0], man}.
- Completion:
  - On the edge leaving ENC: result and sat update, valid=1 for one cycle, and busy drops to 0 in the same edge.
  - acc_clear = valid when CLEAR_AFTER_READ=1.
- Latency: start sampled at edge T; valid high during cycle T+4..T+5. Throughput is one conversion per 5 cycles.
  - Back-to-back operation: start may be asserted in the cycle where valid=1; the FSM is in IDLE then and accepts it.
- Integration rule: the accumulator must not be updated during RD_LO/RD_HI. Hold the MAC inputs at 8'h00 (product 0). A torn read is not detected.

Test Plan:
- Reset, then start with acc=0, shamt=0 -> out_HL high exactly one cycle (2nd cycle after accept); valid 4 cycles after accept; result=8'h00, sat=0, acc_clear pulse coincident.
- acc=5 -> 8'h05; acc=8 -> 8'h08; acc=13 -> 8'h0D; acc=31 -> 8'h18 (round carry into exp).
- acc=100, shamt=0 -> 8'h25 (tie rounds up). acc=-100 (hi=17'h1FFFF, lo=17'h1FF9C) -> 8'hA5.
- acc=2^20, shamt=0 -> 8'h7F, sat=1. Same acc, shamt=6 -> 8'h60, sat=0. acc=-2^33, shamt=0 -> 8'hFF, sat=1.
- start pulsed during RD_HI -> ignored (exactly one valid). start held continuously -> a valid every 5 cycles.
- reset asserted in MAG -> next cycle all outputs at reset values, no valid, no acc_clear. A new start afterwards works normally. With CLEAR_AFTER_READ=0, acc_clear stays 0.

Source files
------------

// File: rtl/tpu_acc_requantizer.sv
// tpu_acc_requantizer: reads the 34-bit MAC accumulator in two 17-bit beats,
// applies a right-shift scale and re-encodes the value as an 8-bit minifloat
// {sign, exp[3:0], man[2:0]} with round-half-away and saturation.
module tpu_acc_requantizer #(
    parameter int unsigned CLEAR_AFTER_READ = 1,
    parameter int unsigned SHAMT_W          = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [16:0]        acc_half,
    output logic               out_HL,
    output logic               acc_clear,
    output logic               busy,
    output logic               valid,
    output logic [7:0]         result,
    output logic               sat
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        MAG,
        ENC
    } state_t;

    state_t state, state_next;

    logic [SHAMT_W-1:0] shamt_r;
    logic [16:0]        lo_r;
    logic [16:0]        hi_r;
    logic               sign_r;
    logic [33:0]        scaled_r;

    logic [33:0] acc;
    logic [33:0] mag;
    logic [33:0] scaled_d;

    logic [5:0]  p;
    logic [3:0]  win;
    logic [3:0]  man4;
    logic [5:0]  exp6;
    logic [7:0]  enc;
    logic        enc_sat;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD_LO;
            RD_LO:   state_next = RD_HI;
            RD_HI:   state_next = MAG;
            MAG:     state_next = ENC;
            ENC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs: the high half is selected only while in RD_HI
    always_comb begin
        out_HL = (state == RD_HI);
        busy   = (state != IDLE);
    end

    assign acc_clear = (CLEAR_AFTER_READ != 0) ? valid : 1'b0;

    // Magnitude of the assembled accumulator; -2^33 maps to 2^33 without overflow
    always_comb begin
        acc      = {hi_r, lo_r};
        mag      = acc[33] ? (~acc + 34'd1) : acc;
        scaled_d = mag >> shamt_r;
    end

    // Minifloat encoder: leading-one position, 3-bit mantissa, round bit, saturation
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 34; i++) begin
            if (scaled_r[i]) p = 6'(i);
        end
        // win holds {man[2:0], round}; for p == 3 there is no round bit
        if (p >= 6'd4) win = 4'(scaled_r >> (p - 6'd4));
        else           win = {scaled_r[2:0], 1'b0};
        man4 = {1'b0, win[3:1]} + {3'b000, win[0]};
        exp6 = p - 6'd2 + {5'b00000, man4[3]};

        enc     = 8'h00;
        enc_sat = 1'b0;
        if (scaled_r == '0) begin
            enc = 8'h00;
        end else if (scaled_r < 34'd8) begin
            enc = {sign_r, 4'd0, scaled_r[2:0]};
        end else if (p > 6'd17 || exp6 >= 6'd16) begin
            enc     = {sign_r, 7'h7F};
            enc_sat = 1'b1;
        end else begin
            enc = {sign_r, exp6[3:0], man4[2:0]};
        end
    end

    // Datapath registers: shift capture, two-beat read, magnitude/scale, result
    always_ff @(posedge clk) begin
        if (reset) begin
            shamt_r  <= '0;
            lo_r     <= '0;
            hi_r     <= '0;
            sign_r   <= 1'b0;
            scaled_r <= '0;
            result   <= 8'h00;
            sat      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE:  if (start) shamt_r <= shamt;
                RD_LO: lo_r <= acc_half;
                RD_HI: hi_r <= acc_half;
                MAG: begin
                    sign_r   <= acc[33];
                    scaled_r <= scaled_d;
                end
                ENC: begin
                    result <= enc;
                    sat    <= enc_sat;
                    valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_acc_requantizer.sv
// Testbench for tpu_acc_requantizer: directed vector table, randomized values
// against an arithmetic reference model, and multi-cycle protocol sequences.
module tb_tpu_acc_requantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  shamt;
    logic [33:0] acc_val;

    logic [16:0] acc_half0, acc_half1;
    logic        hl0, hl1, clr0, clr1, busy0, busy1, valid0, valid1, sat0, sat1;
    logic [7:0]  res0, res1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // MAC half-select model: each DUT sees the half it selects
    assign acc_half0 = hl0 ? acc_val[33:17] : acc_val[16:0];
    assign acc_half1 = hl1 ? acc_val[33:17] : acc_val[16:0];

    tpu_acc_requantizer #(.CLEAR_AFTER_READ(1), .SHAMT_W(5)) dut0 (
        .clk(clk), .reset(reset), .start(start), .shamt(shamt),
        .acc_half(acc_half0), .out_HL(hl0), .acc_clear(clr0), .busy(busy0),
        .valid(valid0), .result(res0), .sat(sat0)
    );

    tpu_acc_requantizer #(.CLEAR_AFTER_READ(0), .SHAMT_W(5)) dut1 (
        .clk(clk), .reset(reset), .start(start), .shamt(shamt),
        .acc_half(acc_half1), .out_HL(hl1), .acc_clear(clr1), .busy(busy1),
        .valid(valid1), .result(res1), .sat(sat1)
    );

    typedef struct {
        logic [33:0] acc;
        logic [4:0]  sh;
        logic [7:0]  res;
        logic        sat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real-valued magnitude, shift, then nearest 4-bit significand
    function automatic logic [8:0] model(input logic [33:0] a, input int sh);
        longint v, m, s, q;
        int     p, e;
        logic   neg;
        logic [3:0] e4;
        logic [3:0] q4;
        v   = longint'({30'd0, a});
        if (a[33]) v = v - (longint'(1) << 34);
        neg = (v < 0);
        m   = neg ? -v : v;
        s   = m >> sh;
        if (s == 0) return 9'h000;
        p = 0;
        while ((s >> (p + 1)) != 0) p++;
        if (p < 3) begin
            q4 = 4'(s);
            return {1'b0, neg, 4'd0, q4[2:0]};
        end
        q = s >> (p - 3);
        if (p >= 4 && ((s >> (p - 4)) & 1) == 1) q++;
        e = p - 2;
        if (q == 16) begin
            q = 8;
            e++;
        end
        if (p > 17 || e >= 16) return {1'b1, neg, 7'h7F};
        e4 = 4'(e);
        q4 = 4'(q);
        return {1'b0, neg, e4, q4[2:0]};
    endfunction

    // Full transaction with cycle-by-cycle protocol checks
    task automatic run_one(input logic [33:0] a, input logic [4:0] sh,
                           input logic [7:0] er, input logic es, input string nm);
        @(negedge clk);
        acc_val = a;
        shamt   = sh;
        start   = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                shamt = 5'($urandom);
            end
            chk({nm, ".out_HL"}, 64'(hl0), 64'(k == 2));
            chk({nm, ".busy"}, 64'(busy0), 64'(k <= 4));
            chk({nm, ".valid"}, 64'(valid0), 64'(k == 5));
            chk({nm, ".acc_clear"}, 64'(clr0), 64'(k == 5));
            chk({nm, ".acc_clear_off"}, 64'(clr1), 64'd0);
            if (k >= 5) begin
                chk({nm, ".result"}, 64'(res0), 64'(er));
                chk({nm, ".sat"}, 64'(sat0), 64'(es));
                chk({nm, ".result_noclr"}, 64'(res1), 64'(er));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".out_HL"}, 64'(hl0), 64'd0);
        chk({nm, ".acc_clear"}, 64'(clr0), 64'd0);
        chk({nm, ".busy"}, 64'(busy0), 64'd0);
        chk({nm, ".valid"}, 64'(valid0), 64'd0);
        chk({nm, ".result"}, 64'(res0), 64'd0);
        chk({nm, ".sat"}, 64'(sat0), 64'd0);
        chk({nm, ".busy1"}, 64'(busy1), 64'd0);
        chk({nm, ".result1"}, 64'(res1), 64'd0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [8:0]  mres;
        logic [33:0] ra;
        logic [4:0]  rs;
        int          nv, vpos[$];

        vecs.push_back('{34'd0,          5'd0,  8'h00, 1'b0});
        vecs.push_back('{34'd5,          5'd0,  8'h05, 1'b0});
        vecs.push_back('{34'd8,          5'd0,  8'h08, 1'b0});
        vecs.push_back('{34'd13,         5'd0,  8'h0D, 1'b0});
        vecs.push_back('{34'd31,         5'd0,  8'h18, 1'b0});
        vecs.push_back('{34'd100,        5'd0,  8'h25, 1'b0});
        vecs.push_back('{34'h3FFFFFF9C,  5'd0,  8'hA5, 1'b0});
        vecs.push_back('{34'h3FFFFFFFB,  5'd0,  8'h85, 1'b0});
        vecs.push_back('{34'h000100000,  5'd0,  8'h7F, 1'b1});
        vecs.push_back('{34'h000100000,  5'd6,  8'h60, 1'b0});
        vecs.push_back('{34'h200000000,  5'd0,  8'hFF, 1'b1});
        vecs.push_back('{34'h200000000,  5'd31, 8'h84, 1'b0});
        vecs.push_back('{34'h00003C000,  5'd0,  8'h7F, 1'b0});
        vecs.push_back('{34'h00003FFFF,  5'd0,  8'h7F, 1'b1});
        vecs.push_back('{34'h3FFFFFFFF,  5'd1,  8'h00, 1'b0});

        reset   = 1'b1;
        start   = 1'b0;
        shamt   = '0;
        acc_val = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        foreach (vecs[i])
            run_one(vecs[i].acc, vecs[i].sh, vecs[i].res, vecs[i].sat, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            int w;
            w  = $urandom_range(0, 33);
            ra = {2'($urandom), $urandom} & ((34'd1 << w) - 34'd1);
            if ($urandom_range(0, 1) == 1) ra = ~ra + 34'd1;
            rs = 5'($urandom_range(0, 12));
            mres = model(ra, int'(rs));
            run_one(ra, rs, mres[7:0], mres[8], $sformatf("rnd%0d", i));
        end

        // start pulsed while in RD_HI is ignored
        @(negedge clk);
        acc_val = 34'd13;
        shamt   = 5'd0;
        start   = 1'b1;
        nv      = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (valid0) nv++;
        end
        chk("rdhi_start.valid_count", 64'(nv), 64'd1);

        // start held high: one conversion every 5 cycles
        @(negedge clk);
        acc_val = 34'd8;
        start   = 1'b1;
        vpos.delete();
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (valid0) vpos.push_back(k);
            if (k == 25) start = 1'b0;
        end
        chk("held.valid_count", 64'(vpos.size()), 64'd5);
        foreach (vpos[i]) chk($sformatf("held.valid_pos%0d", i), 64'(vpos[i]), 64'(5 * (i + 1)));
        chk("held.result", 64'(res0), 64'h08);
        repeat (6) @(negedge clk);

        // reset while in MAG aborts the conversion (previous result is nonzero)
        run_one(34'd100, 5'd0, 8'h25, 1'b0, "pre_abort");
        @(negedge clk);
        acc_val = 34'h000100000;
        start   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        reset = 1'b0;
        nv    = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (valid0 || clr0 || valid1) nv++;
        end
        chk("abort.no_valid", 64'(nv), 64'd0);
        run_one(34'd31, 5'd0, 8'h18, 1'b0, "post_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
